// File: rtl/sm83_intctl.sv
`default_nettype none
// ============================================================================
// Module   : sm83_intctl
// Purpose  : Interrupt flag/enable register pair for the sm83 core. Latches
//            rising edges of peripheral request lines into IF, masks them
//            with IE and presents the result on the core's irq vector. The
//            core's one-hot iack clears the serviced flag. Priority and IME
//            are handled by the core.
// Ports    : clk, reset      - system clock, synchronous active-high reset
//            adr, din        - CPU address bus and write data
//            wr, rd          - write / read strobes qualified by adr
//            dout, dout_oe   - combinational read data and its enable
//            src             - peripheral request levels (rising edge = req)
//            irq, wake       - pending & enabled vector, OR of irq
//            iack            - one-hot acknowledge from the core
// Revision : 1.0 - initial release
// ============================================================================
module sm83_intctl #(
  parameter int          NUM_SRC = 5,
  parameter logic [15:0] IF_ADR  = 16'hff0f,
  parameter logic [15:0] IE_ADR  = 16'hffff
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        adr,
  input  logic [7:0]         din,
  input  logic               wr,
  input  logic               rd,
  output logic [7:0]         dout,
  output logic               dout_oe,
  input  logic [NUM_SRC-1:0] src,
  output logic [7:0]         irq,
  input  logic [7:0]         iack,
  output logic               wake
);

  logic [NUM_SRC-1:0] if_q;
  logic [7:0]         ie_q;
  logic [NUM_SRC-1:0] src_q;

  logic               sel_if;
  logic               sel_ie;
  logic [NUM_SRC-1:0] rise;
  logic [7:0]         if_rd;

  assign sel_if = (adr == IF_ADR);
  assign sel_ie = (adr == IE_ADR);
  assign rise   = src & ~src_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      if_q  <= '0;
      ie_q  <= 8'h00;
      // All ones so a source already high when reset releases is not an edge.
      src_q <= '1;
    end else begin
      src_q <= src;
      // A fresh edge is OR-ed in last so it survives both a write and an ack.
      if (wr && sel_if)
        if_q <= din[NUM_SRC-1:0] | rise;
      else
        if_q <= (if_q & ~iack[NUM_SRC-1:0]) | rise;
      if (wr && sel_ie)
        ie_q <= din;
    end
  end

  // Per-bit build of the 8-bit views; bits above NUM_SRC read as 1 in IF
  // and are forced to 0 on irq.
  for (genvar i = 0; i < 8; i++) begin : g_bit
    if (i < NUM_SRC) begin : g_src
      assign if_rd[i] = if_q[i];
      assign irq[i]   = if_q[i] & ie_q[i];
    end else begin : g_pad
      assign if_rd[i] = 1'b1;
      assign irq[i]   = 1'b0;
    end
  end

  assign wake = |irq;

  always_comb begin
    dout    = 8'hff;
    dout_oe = 1'b0;
    if (rd && sel_if) begin
      dout    = if_rd;
      dout_oe = 1'b1;
    end else if (rd && sel_ie) begin
      dout    = ie_q;
      dout_oe = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sm83_intctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sm83_intctl
// Purpose  : Directed self-checking bench for sm83_intctl. Expected values
//            are queued when stimulus is applied and popped when the DUT
//            output is sampled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sm83_intctl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] adr;
  logic [7:0]  din;
  logic        wr;
  logic        rd;
  logic [7:0]  dout;
  logic        dout_oe;
  logic [4:0]  src;
  logic [7:0]  irq;
  logic [7:0]  iack;
  logic        wake;

  sm83_intctl #(.NUM_SRC(5), .IF_ADR(16'hff0f), .IE_ADR(16'hffff)) dut (
    .clk(clk), .reset(reset), .adr(adr), .din(din), .wr(wr), .rd(rd),
    .dout(dout), .dout_oe(dout_oe), .src(src), .irq(irq), .iack(iack),
    .wake(wake)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic push(input string tag, input logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [7:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty: observed %h required a queued expectation", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed %h required %h", e.tag, obs, e.val);
      end
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
    adr = a; din = d; wr = 1'b1;
    tick();
    wr = 1'b0; adr = 16'h0000;
  endtask

  task automatic bus_rd(input string tag, input logic [15:0] a,
                        input logic [7:0] exp_d, input logic exp_oe);
    adr = a; rd = 1'b1;
    push({tag, "_dout"}, exp_d);
    push({tag, "_oe"}, {7'b0, exp_oe});
    #1;
    check(dout);
    check({7'b0, dout_oe});
    rd = 1'b0; adr = 16'h0000;
  endtask

  task automatic chk_irq(input string tag, input logic [7:0] exp_irq);
    push({tag, "_irq"}, exp_irq);
    push({tag, "_wake"}, {7'b0, |exp_irq});
    check(irq);
    check({7'b0, wake});
  endtask

  initial begin
    reset = 1'b1; adr = 16'h0000; din = 8'h00; wr = 1'b0; rd = 1'b0;
    src = 5'h1f; iack = 8'h00;
    #1;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset values with all sources held high
    chk_irq("rst", 8'h00);
    bus_rd("rst_if", 16'hff0f, 8'he0, 1'b1);
    bus_rd("rst_ie", 16'hffff, 8'h00, 1'b1);
    bus_rd("idle", 16'h0000, 8'hff, 1'b0);
    tick(); tick();
    bus_rd("rst_hold_if", 16'hff0f, 8'he0, 1'b1);
    src = 5'h00;
    tick();
    bus_rd("rst_fall_if", 16'hff0f, 8'he0, 1'b1);

    // Edge and enable
    bus_wr(16'hffff, 8'h04);
    src = 5'h04;
    chk_irq("edge_n", 8'h00);
    tick();
    chk_irq("edge_n1", 8'h04);
    tick();
    bus_rd("level_once", 16'hff0f, 8'he4, 1'b1);
    iack = 8'h04;
    tick();
    iack = 8'h00;
    chk_irq("ack", 8'h00);
    bus_rd("ack_if", 16'hff0f, 8'he0, 1'b1);
    tick();
    bus_rd("level_hold", 16'hff0f, 8'he0, 1'b1);
    src = 5'h00;
    tick();

    // Masking
    bus_wr(16'hffff, 8'h00);
    src = 5'h11;
    tick();
    src = 5'h00;
    bus_rd("mask_if", 16'hff0f, 8'hf1, 1'b1);
    chk_irq("mask", 8'h00);
    bus_wr(16'hffff, 8'h11);
    chk_irq("unmask", 8'h11);

    // Simultaneous events
    bus_wr(16'hff0f, 8'h02);
    bus_rd("sim_set", 16'hff0f, 8'he2, 1'b1);
    iack = 8'h02; src = 5'h0a;
    tick();
    iack = 8'h00;
    bus_rd("sim_ack_edge", 16'hff0f, 8'hea, 1'b1);
    src = 5'h0b;
    bus_wr(16'hff0f, 8'h00);
    bus_rd("sim_wr_edge", 16'hff0f, 8'he1, 1'b1);
    src = 5'h00;
    iack = 8'h04;
    bus_wr(16'hff0f, 8'h04);
    iack = 8'h00;
    bus_rd("wr_beats_ack", 16'hff0f, 8'he4, 1'b1);
    iack = 8'he0;
    tick();
    iack = 8'h00;
    bus_rd("ack_hi_ign", 16'hff0f, 8'he4, 1'b1);

    // Bus decode
    bus_wr(16'hff0f, 8'hff);
    bus_rd("if_ff", 16'hff0f, 8'hff, 1'b1);
    bus_wr(16'hffff, 8'ha5);
    bus_rd("ie_a5", 16'hffff, 8'ha5, 1'b1);
    chk_irq("ie_a5", 8'h05);
    bus_wr(16'hff0e, 8'h00);
    bus_rd("ff0e_if", 16'hff0f, 8'hff, 1'b1);
    bus_rd("ff0e_ie", 16'hffff, 8'ha5, 1'b1);
    bus_rd("c000", 16'hc000, 8'hff, 1'b0);
    adr = 16'hff0f; rd = 1'b0;
    push("rd_low_dout", 8'hff);
    push("rd_low_oe", 8'h00);
    #1;
    check(dout);
    check({7'b0, dout_oe});
    adr = 16'h0000;

    // Read during write returns the pre-write value
    adr = 16'hffff; din = 8'h1f; wr = 1'b1; rd = 1'b1;
    push("rdw_ie", 8'ha5);
    #1;
    check(dout);
    tick();
    wr = 1'b0; rd = 1'b0;
    chk_irq("pend_all", 8'h1f);

    // Reset mid-operation together with a write and an edge
    reset = 1'b1; adr = 16'hffff; din = 8'hff; wr = 1'b1; src = 5'h01;
    tick();
    reset = 1'b0; wr = 1'b0; adr = 16'h0000;
    chk_irq("mid_rst", 8'h00);
    bus_rd("mid_rst_ie", 16'hffff, 8'h00, 1'b1);
    bus_rd("mid_rst_if", 16'hff0f, 8'he0, 1'b1);
    bus_rd("mid_rst_idle", 16'h0000, 8'hff, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/sm83_intctl.md
# sm83_intctl

Interrupt controller sitting beside the sm83 core on its memory bus. It holds the IF (0xFF0F) and IE (0xFFFF) registers, turns peripheral request lines into latched flags, and drives the core's `irq` vector with `IF & IE`. The core's one-hot `iack` clears the serviced flag. The core itself performs priority selection and IME handling.

## Interface
Parameters:
- `NUM_SRC`, 5: number of interrupt sources, mapped to IF/IRQ bits [NUM_SRC-1:0].
- `IF_ADR`, 16'hff0f: address of the IF register.
- `IE_ADR`, 16'hffff: address of the IE register.

Ports:
- `clk`  in  1  single system clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `adr`  in  16  CPU address bus.
- `din`  in  8  CPU write data.
- `wr`  in  1  one-cycle write strobe, qualified by `adr`.
- `rd`  in  1  read strobe, qualified by `adr`.
- `dout`  out  8  read data.
- `dout_oe`  out  1  high when `rd` is high and `adr` matches IF_ADR or IE_ADR.
- `src`  in  NUM_SRC  peripheral request levels; a rising edge raises a request.
- `irq`  out  8  pending and enabled interrupts, to the core's `irq`.
- `iack`  in  8  one-hot acknowledge from the core's `iack`.
- `wake`  out  1  OR of `irq`, used to release HALT.

## Operation
- **State:**
  - `if_q[NUM_SRC-1:0]`, the flags.
  - `ie_q[7:0]`, the enables.
  - `src_q[NUM_SRC-1:0]`, the previous `src`.
- **Edge detect:** `rise = src & ~src_q`. `src_q <= src` every cycle.
- **IF next value:** `if_q <= (wr_if ? din[NUM_SRC-1:0] : if_q & ~iack[NUM_SRC-1:0]) | rise`, where `wr_if = wr && adr == IF_ADR`.
  - A new edge always wins over a CPU write or an `iack` clear in the same cycle.
  - A CPU write in the same cycle as `iack` takes the written value; `iack` is ignored.
  - `iack` bits at or above NUM_SRC are ignored.
- **IE next value:** `ie_q <= din` when `wr && adr == IE_ADR`. All 8 bits are stored and read back.
- **irq:** `irq[NUM_SRC-1:0] = if_q & ie_q[NUM_SRC-1:0]`. `irq[7:NUM_SRC] = 0`.
- **wake:** `wake = |irq`.
- **Read data (combinational from current state):**
  - IF reads `{ {8-NUM_SRC{1'b1}}, if_q }`, i.e. 0xE0 | flags when NUM_SRC = 5.
  - IE reads `ie_q`.
  - Any other address, or `rd` low, gives `dout = 8'hff` and `dout_oe = 0`.
- **Read during write:** a read in the same cycle as a write to the same register returns the pre-write value.
- **Reset (synchronous, wins over everything):**
  - `if_q = 0`, `ie_q = 0`.
  - `src_q = all ones`, so a source held high through reset does not fire on release.
  - Outputs in reset cycle +1: `irq = 0`, `wake = 0`, `dout = 8'hff`, `dout_oe = 0`.
- If reset is asserted in the same cycle as an edge, a write, or an `iack`, all of them are discarded.

## Timing
- **Source edge to irq:** `src` rises in cycle n. `if_q` is set at the end of n. `irq` and `wake` are high in cycle n+1 (when enabled). Latency is 1 clock.
- **Write to effect:** an IF or IE write in cycle n is visible on `irq` and `dout` in cycle n+1.
- **Acknowledge:** `iack` in cycle n clears the bit at the end of n; `irq` drops in n+1. If another `src` edge arrives in n, the bit stays set.
- **Level sources:** a `src` held high produces exactly one flag set. It must drop and rise again to raise another request.
- **Read path:** `dout` / `dout_oe` are combinational from `adr`/`rd` and register state, with no added cycles. This fits the core's data latch, sampled while `lh` is low.

## Test plan
- **Reset values:** assert reset with `src = 5'h1f` held, then release. Required: `irq = 0`; a read of 0xFF0F returns 0xE0; a read of 0xFFFF returns 0x00; no flag is set while `src` stays high.
- **Edge and enable:** write IE = 0x04, pulse `src[2]` 0→1. Required: `irq = 8'h04` and `wake = 1` exactly one cycle after the edge. Then `iack = 8'h04`: `irq = 0` the next cycle, and IF reads 0xE0.
- **Masking:** IE = 0x00, rising edges on `src[0]` and `src[4]`. Required: IF reads 0xF1, `irq = 0`, `wake = 0`. Then write IE = 0x11: `irq = 8'h11` on the next cycle.
- **Simultaneous events:** set IF bit 1, then in one cycle apply `iack = 8'h02`, a `src[1]` edge, and a `src[3]` edge. Required: IF reads 0xEA. Next, in one cycle write IF = 0x00 with a `src[0]` edge: IF reads 0xE1.
- **Bus decode:**
  - Write 0xFF to IF: reads back 0xFF.
  - Write 0xA5 to IE: reads back 0xA5, and `irq[7:5] = 0` always.
  - A write to 0xFF0E changes nothing.
  - `rd` at 0xC000 gives `dout_oe = 0`, `dout = 0xFF`.
- **Reset mid-operation:** with `irq = 8'h1f` pending, assert reset in the same cycle as a write of 0xFF to IE. Required: next cycle IE = 0, IF = 0, `irq = 0`.
